serial_subtractor: RTL

Bit-serial unsigned subtractor that computes a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It complements the combinational full-adder cell used elsewhere in the lab designs: it runs the arithmetic in the other direction and trades latency for area. It sits behind a start/done handshake, so a controller can issue operands and collect a registered result.

---
 rtl/serial_subtractor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. Computes a - b - bin one bit per clock,
// LSB first, with a single full-subtractor cell and a registered borrow.
// A start/done handshake wraps the datapath. The result and the borrow-out
// are registered, and they only change when a run completes.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  minuend, captured when start is accepted
//   b      in   WIDTH  subtrahend, captured when start is accepted
//   bin    in   1      borrow-in, captured when start is accepted
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when diff/bout carry a new result
//   diff   out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout   out  1      1 iff a < b + bin (unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // The counter needs at least one bit, even for the smallest widths.
    localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // One full-subtractor cell. The return value is {borrow_out, difference}.
    function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic r);
        logic d_bit;
        logic b_bit;
        d_bit = x ^ y ^ r;
        b_bit = (~x & y) | (~(x ^ y) & r);
        return {b_bit, d_bit};
    endfunction

    // State and datapath registers
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    // Next-state values
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_a_sr_nxt;
    logic [WIDTH-1:0] w_b_sr_nxt;
    logic             w_borrow_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_bout_nxt;

    // Cell outputs and the result register as it looks after this bit
    logic [1:0]       w_cell;
    logic [WIDTH-1:0] w_res_shifted;
    logic             w_last_bit;

    // Evaluate the subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        w_cell        = fs_cell(r_a_sr[0], r_b_sr[0], r_borrow);
        // The new difference bit enters at the MSB. After WIDTH shifts the
        // first (LSB) difference bit has travelled down to bit 0.
        w_res_shifted = {w_cell[0], r_res[WIDTH-1:1]};
        w_last_bit    = (r_cnt == CNT_LAST);
    end

    // Sequencing: accept in IDLE, shift WIDTH bits, present the result for one cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_sr_nxt   = r_a_sr;
        w_b_sr_nxt   = r_b_sr;
        w_borrow_nxt = r_borrow;
        w_cnt_nxt    = r_cnt;
        w_res_nxt    = r_res;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_diff_nxt   = r_diff;
        w_bout_nxt   = r_bout;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_SHIFT;
                    w_a_sr_nxt   = a;
                    w_b_sr_nxt   = b;
                    w_borrow_nxt = bin;
                    w_cnt_nxt    = CNT_ZERO;
                    w_res_nxt    = {WIDTH{1'b0}};
                    w_busy_nxt   = 1'b1;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_busy_nxt   = 1'b0;
                end
            end

            S_SHIFT: begin
                w_a_sr_nxt   = {1'b0, r_a_sr[WIDTH-1:1]};
                w_b_sr_nxt   = {1'b0, r_b_sr[WIDTH-1:1]};
                w_borrow_nxt = w_cell[1];
                w_res_nxt    = w_res_shifted;
                w_cnt_nxt    = r_cnt + CNT_ONE;
                if (w_last_bit) begin
                    // diff/bout are loaded only here, so a partial result
                    // never reaches the outputs.
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_diff_nxt  = w_res_shifted;
                    w_bout_nxt  = w_cell[1];
                end else begin
                    w_state_nxt = S_SHIFT;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_DONE: begin
                // start is ignored here, so the issue interval is WIDTH+2.
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= {WIDTH{1'b0}};
            r_b_sr   <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_cnt    <= CNT_ZERO;
            r_res    <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= {WIDTH{1'b0}};
            r_bout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a_sr   <= w_a_sr_nxt;
            r_b_sr   <= w_b_sr_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_res    <= w_res_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_diff   <= w_diff_nxt;
            r_bout   <= w_bout_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
